// File: rtl/apb_arb_pkg.sv
// Shared types and default sizing for the two-requester APB master arbiter.
package apb_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 16;
  localparam int CNT_WIDTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant; the pointer only moves when a grant is actually taken.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic       APB_pclk,
  input  logic       APB_presetn,
  input  logic       arb_en,
  input  logic [1:0] req_valid,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  // last_q holds the most recently granted requester; reset value 1 favours requester 0
  req_id_t last_q;
  req_id_t last_d;

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (arb_en) begin
      case (req_valid)
        2'b01: begin
          grant    = 2'b01;
          grant_id = 1'b0;
        end
        2'b10: begin
          grant    = 2'b10;
          grant_id = 1'b1;
        end
        2'b11: begin
          grant    = last_q ? 2'b01 : 2'b10;
          grant_id = ~last_q;
        end
        default: begin
          grant    = 2'b00;
          grant_id = 1'b0;
        end
      endcase
    end
    last_d = (|grant) ? grant_id : last_q;
  end

  always_ff @(posedge APB_pclk or negedge APB_presetn) begin
    if (!APB_presetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two command requesters onto a single APB master port with
// wait-state handling, slave error reporting and an ACCESS-phase timeout.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  APB_pclk,
  input  logic                  APB_presetn,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_write_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  output logic                  rsp_err_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_write_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  rsp_err_1,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam logic [CNT_WIDTH:0] TIMEOUT_LIM = (CNT_WIDTH+1)'(TIMEOUT);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  req_id_t               owner_q, owner_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pselx_q, pselx_d;
  logic                  penable_q, penable_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  arb_en;
  logic [1:0]            grant;
  req_id_t               grant_id;

  // Grants are withheld during reset and while a response pulse is on the outputs
  assign arb_en = APB_presetn && (state_q == ST_IDLE) && (rsp_valid_q == 2'b00);

  apb_rr_arbiter u_rr (
    .APB_pclk    (APB_pclk),
    .APB_presetn (APB_presetn),
    .arb_en      (arb_en),
    .req_valid   ({req_valid_1, req_valid_0}),
    .grant       (grant),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          owner_d  = grant_id;
          pwrite_d = grant_id ? req_write_1 : req_write_0;
          paddr_d  = grant_id ? req_addr_1  : req_addr_0;
          pwdata_d = grant_id ? req_wdata_1 : req_wdata_0;
          cnt_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d              = ST_IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = pslverr;
          rsp_data_d           = pwrite_q ? '0 : prdata;
        end else if (({1'b0, cnt_q} + 1'b1) >= TIMEOUT_LIM) begin
          state_d              = ST_IDLE;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
          rsp_data_d           = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pselx_d   = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge APB_pclk or negedge APB_presetn) begin
    if (!APB_presetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign pselx       = pselx_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_err_0   = rsp_valid_q[0] & rsp_err_q;
  assign rsp_err_1   = rsp_valid_q[1] & rsp_err_q;
  assign rsp_rdata_0 = rsp_valid_q[0] ? rsp_data_q : '0;
  assign rsp_rdata_1 = rsp_valid_q[1] ? rsp_data_q : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a simple programmable APB slave.
module tb_apb_req_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          APB_pclk = 1'b0;
  logic          APB_presetn;
  logic          req_valid_0, req_write_0, req_valid_1, req_write_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          req_ready_0, req_ready_1;
  logic          rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic          pselx, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready, pslverr;

  int checks = 0;
  int errors = 0;

  int            slv_waits = 0;
  logic          slv_err   = 1'b0;
  logic [DW-1:0] slv_rdata = '0;
  int            acc_cnt   = 0;

  apb_req_arbiter dut (
    .APB_pclk    (APB_pclk),
    .APB_presetn (APB_presetn),
    .req_valid_0 (req_valid_0),
    .req_ready_0 (req_ready_0),
    .req_write_0 (req_write_0),
    .req_addr_0  (req_addr_0),
    .req_wdata_0 (req_wdata_0),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_rdata_0 (rsp_rdata_0),
    .rsp_err_0   (rsp_err_0),
    .req_valid_1 (req_valid_1),
    .req_ready_1 (req_ready_1),
    .req_write_1 (req_write_1),
    .req_addr_1  (req_addr_1),
    .req_wdata_1 (req_wdata_1),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_rdata_1 (rsp_rdata_1),
    .rsp_err_1   (rsp_err_1),
    .pselx       (pselx),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 APB_pclk = ~APB_pclk;

  // Slave answers on the (slv_waits+1)-th ACCESS cycle; inputs change 1 time unit after each edge
  always @(posedge APB_pclk) begin
    #1;
    if (pselx && penable) begin
      if (acc_cnt == slv_waits) begin
        pready  = 1'b1;
        pslverr = slv_err;
        prdata  = slv_rdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
      end
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      acc_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge APB_pclk);
    #1;
  endtask

  // Called in the accept cycle; n counts edges until the chosen rsp_valid is seen, -1 if never
  task automatic wait_rsp(input bit which, input bit clr0, input bit clr1, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 1) begin
        if (clr0) req_valid_0 = 1'b0;
        if (clr1) req_valid_1 = 1'b0;
      end
      if ((which ? rsp_valid_1 : rsp_valid_0) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    APB_presetn = 1'b0;
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    #2;
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_apb got %b want 0", {pselx, penable, pwrite, paddr, pwdata});
    end
    checks++;
    if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1} !== 6'b0 ||
        rsp_rdata_0 !== '0 || rsp_rdata_1 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req got rdy=%b%b vld=%b%b want 00 00",
               req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1);
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    tick();
    tick();
    APB_presetn = 1'b1;
    #1;
  endtask

  task automatic test_contention();
    int n;
    slv_waits = 0; slv_err = 1'b0; slv_rdata = 16'h0A0A;
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 8'h05; req_wdata_0 = 16'h0000;
    req_valid_1 = 1'b1; req_write_1 = 1'b1; req_addr_1 = 8'h06; req_wdata_1 = 16'h0606;
    #1;
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL cont_first_grant got %b%b want 01", req_ready_1, req_ready_0);
    end
    wait_rsp(1'b0, 1'b0, 1'b0, n);
    checks++;
    if (n !== 3 || rsp_rdata_0 !== 16'h0A0A || rsp_valid_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cont_rsp0 got n=%0d rdata=%h v1=%b want 3 0a0a 0", n, rsp_rdata_0, rsp_valid_1);
    end
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b00 || paddr !== 8'h05) begin
      errors++;
      $display("[TB] FAIL cont_no_grant_on_rsp got rdy=%b%b paddr=%h want 00 05",
               req_ready_1, req_ready_0, paddr);
    end
    tick();
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cont_loser_next got %b%b want 10", req_ready_1, req_ready_0);
    end
    wait_rsp(1'b1, 1'b0, 1'b1, n);
    checks++;
    if (n !== 3 || rsp_rdata_1 !== '0 || rsp_err_1 !== 1'b0 || pwrite !== 1'b1 || pwdata !== 16'h0606) begin
      errors++;
      $display("[TB] FAIL cont_rsp1 got n=%0d rdata=%h err=%b pwrite=%b pwdata=%h want 3 0000 0 1 0606",
               n, rsp_rdata_1, rsp_err_1, pwrite, pwdata);
    end
    req_valid_1 = 1'b1;
    tick();
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL cont_third_grant got %b%b want 01", req_ready_1, req_ready_0);
    end
    wait_rsp(1'b0, 1'b1, 1'b0, n);
    tick();
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cont_fourth_grant got %b%b want 10", req_ready_1, req_ready_0);
    end
    wait_rsp(1'b1, 1'b0, 1'b1, n);
    tick();
  endtask

  task automatic test_single_write();
    slv_waits = 0; slv_err = 1'b0; slv_rdata = 16'h5555;
    req_valid_0 = 1'b1; req_write_0 = 1'b1; req_addr_0 = 8'h20; req_wdata_0 = 16'hBEEF;
    #1;
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wr_ready got %b%b want 01", req_ready_1, req_ready_0);
    end
    tick();
    req_valid_0 = 1'b0;
    checks++;
    if ({pselx, penable, pwrite} !== 3'b101 || paddr !== 8'h20 || pwdata !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL wr_setup got sel/en/wr=%b addr=%h data=%h want 101 20 beef",
               {pselx, penable, pwrite}, paddr, pwdata);
    end
    tick();
    checks++;
    if ({pselx, penable} !== 2'b11 || paddr !== 8'h20 || rsp_valid_0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_access got sel/en=%b addr=%h v=%b want 11 20 0",
               {pselx, penable}, paddr, rsp_valid_0);
    end
    tick();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_err_0 !== 1'b0 || rsp_rdata_0 !== '0 || {pselx, penable} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wr_rsp got v=%b err=%b rdata=%h sel/en=%b want 1 0 0000 00",
               rsp_valid_0, rsp_err_0, rsp_rdata_0, {pselx, penable});
    end
    tick();
    checks++;
    if (rsp_valid_0 !== 1'b0 || paddr !== 8'h20) begin
      errors++;
      $display("[TB] FAIL wr_pulse_end got v=%b paddr=%h want 0 20", rsp_valid_0, paddr);
    end
  endtask

  task automatic test_wait_states();
    int n;
    int acc;
    slv_waits = 3; slv_err = 1'b0; slv_rdata = 16'h1234;
    req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 8'h33; req_wdata_1 = 16'hFFFF;
    tick();
    req_valid_1 = 1'b0;
    n = 1;
    acc = 0;
    while (rsp_valid_1 !== 1'b1 && n < 20) begin
      checks++;
      if (paddr !== 8'h33 || pselx !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ws_paddr_stable cycle %0d got addr=%h sel=%b want 33 1", n, paddr, pselx);
      end
      if (penable === 1'b1) acc++;
      tick();
      n++;
    end
    checks++;
    if (n !== 6 || acc !== 4) begin
      errors++;
      $display("[TB] FAIL ws_latency got n=%0d access=%0d want 6 4", n, acc);
    end
    checks++;
    if (rsp_rdata_1 !== 16'h1234 || rsp_err_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ws_rdata got %h err=%b want 1234 0", rsp_rdata_1, rsp_err_1);
    end
    tick();
  endtask

  task automatic test_slave_error();
    int n;
    slv_waits = 0; slv_err = 1'b1; slv_rdata = 16'hA5A5;
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 8'h11;
    wait_rsp(1'b0, 1'b1, 1'b0, n);
    checks++;
    if (n !== 3 || rsp_err_0 !== 1'b1 || rsp_rdata_0 !== 16'hA5A5 || paddr !== 8'h11) begin
      errors++;
      $display("[TB] FAIL slverr got n=%0d err=%b rdata=%h addr=%h want 3 1 a5a5 11",
               n, rsp_err_0, rsp_rdata_0, paddr);
    end
    slv_err = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    slv_waits = 255; slv_err = 1'b0; slv_rdata = 16'h7777;
    req_valid_1 = 1'b1; req_write_1 = 1'b0; req_addr_1 = 8'h7E;
    wait_rsp(1'b1, 1'b0, 1'b1, n);
    checks++;
    if (n !== 18 || rsp_err_1 !== 1'b1 || rsp_rdata_1 !== '0) begin
      errors++;
      $display("[TB] FAIL timeout got n=%0d err=%b rdata=%h want 18 1 0000", n, rsp_err_1, rsp_rdata_1);
    end
    checks++;
    if ({pselx, penable} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL timeout_idle got sel/en=%b want 00", {pselx, penable});
    end
    tick();
  endtask

  task automatic test_reset_in_access();
    int n;
    slv_waits = 255; slv_err = 1'b0; slv_rdata = 16'h4444;
    req_valid_0 = 1'b1; req_write_0 = 1'b1; req_addr_0 = 8'h44; req_wdata_0 = 16'hC0DE;
    tick();
    req_valid_0 = 1'b0;
    tick();
    checks++;
    if ({pselx, penable} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL rst_in_access_pre got sel/en=%b want 11", {pselx, penable});
    end
    #2;
    APB_presetn = 1'b0;
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 8'h45;
    req_valid_1 = 1'b1; req_write_1 = 1'b1; req_addr_1 = 8'h46; req_wdata_1 = 16'h0046;
    #1;
    checks++;
    if ({pselx, penable, pwrite, paddr, pwdata} !== '0 || {req_ready_0, req_ready_1} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rst_in_access got apb=%b rdy=%b%b want 0 00",
               {pselx, penable, pwrite, paddr, pwdata}, req_ready_0, req_ready_1);
    end
    tick();
    tick();
    slv_waits = 0;
    APB_presetn = 1'b1;
    #1;
    checks++;
    if ({req_ready_1, req_ready_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rst_ptr_reset got %b%b want 01", req_ready_1, req_ready_0);
    end
    wait_rsp(1'b0, 1'b1, 1'b0, n);
    checks++;
    if (n !== 3 || rsp_rdata_0 !== 16'h4444 || rsp_valid_1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_first_xfer got n=%0d rdata=%h v1=%b want 3 4444 0", n, rsp_rdata_0, rsp_valid_1);
    end
    tick();
    wait_rsp(1'b1, 1'b0, 1'b1, n);
    checks++;
    if (n !== 3 || paddr !== 8'h46) begin
      errors++;
      $display("[TB] FAIL rst_second_xfer got n=%0d addr=%h want 3 46", n, paddr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_reset_in_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
